// File: rtl/b3_down_counter.sv
// b3_down_counter: loadable N-digit base-3 down-counter with a digit-serial
// borrow chain. Each digit is 2 bits (00=0, 01=1, 10=2; 11 never stored).

// One base-3 digit of the borrow chain: subtract the incoming borrow.
module b3_dec_cell (
    input  logic [1:0] d,
    input  logic       bin,
    output logic [1:0] q,
    output logic       bout
);
    // A borrow into a zero digit wraps it to 2 and passes the borrow on.
    always_comb begin
        q    = d;
        bout = 1'b0;
        if (bin) begin
            if (d == 2'b00) begin
                q    = 2'b10;
                bout = 1'b1;
            end else begin
                q = d - 2'b01;
            end
        end
    end
endmodule

module b3_down_counter #(
    parameter int N = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           load,
    input  logic [2*N-1:0] din,
    input  logic           dec,
    output logic [2*N-1:0] count,
    output logic           zero,
    output logic           borrow_out,
    output logic           err
);
    logic [N:0]     chain;
    logic [2*N-1:0] dec_val;
    logic [N-1:0]   digit_bad;
    logic           din_bad;

    // The chain always subtracts one from the LSD.
    assign chain[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_digit
            b3_dec_cell u_cell (
                .d   (count[2*i +: 2]),
                .bin (chain[i]),
                .q   (dec_val[2*i +: 2]),
                .bout(chain[i+1])
            );
            assign digit_bad[i] = (din[2*i +: 2] == 2'b11);
        end
    endgenerate

    assign din_bad = |digit_bad;
    assign zero    = (count == '0);

    // Count register: load beats dec; a rejected load holds count and flags err.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count      <= '0;
            borrow_out <= 1'b0;
            err        <= 1'b0;
        end else if (load) begin
            borrow_out <= 1'b0;
            if (din_bad) begin
                err <= 1'b1;
            end else begin
                count <= din;
                err   <= 1'b0;
            end
        end else if (dec) begin
            count      <= dec_val;
            borrow_out <= chain[N];
        end else begin
            borrow_out <= 1'b0;
        end
    end
endmodule

// File: tb/tb_b3_down_counter.sv
// Scoreboard bench for b3_down_counter: stimulus pushes the model's expected
// post-edge state into a queue; a monitor pops and compares after each edge.
module tb_b3_down_counter;
    localparam int N    = 4;
    localparam int MAXV = 81;   // 3^N

    typedef struct {
        logic [2*N-1:0] count;
        logic           zero;
        logic           borrow;
        logic           err;
    } exp_t;

    logic           clock = 1'b0;
    logic           reset;
    logic           load;
    logic [2*N-1:0] din;
    logic           dec;
    logic [2*N-1:0] count;
    logic           zero;
    logic           borrow_out;
    logic           err;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    // reference model state: plain integer value plus error flag
    int mval;
    bit merr;

    b3_down_counter #(.N(N)) dut (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .din       (din),
        .dec       (dec),
        .count     (count),
        .zero      (zero),
        .borrow_out(borrow_out),
        .err       (err)
    );

    always #5 clock = ~clock;

    function automatic logic [2*N-1:0] enc(input int v);
        logic [2*N-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int k = 0; k < N; k++) begin
            r[2*k +: 2] = 2'(x % 3);
            x = x / 3;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // One cycle of stimulus; model computes the state after the next edge.
    task automatic drive(input bit ld, input logic [2*N-1:0] d, input bit dc);
        exp_t e;
        bit   bad;
        int   v, p;
        @(negedge clock);
        load = ld;
        din  = d;
        dec  = dc;
        e.borrow = 1'b0;
        if (ld) begin
            bad = 0; v = 0; p = 1;
            for (int k = 0; k < N; k++) begin
                if (d[2*k +: 2] == 2'b11) bad = 1;
                v += int'(d[2*k +: 2]) * p;
                p *= 3;
            end
            if (bad) merr = 1;
            else begin
                mval = v;
                merr = 0;
            end
        end else if (dc) begin
            e.borrow = (mval == 0);
            mval = (mval == 0) ? MAXV - 1 : mval - 1;
        end
        e.count = enc(mval);
        e.zero  = (mval == 0);
        e.err   = merr;
        sb_q.push_back(e);
    endtask

    // Reset asserted mid-cycle with dec active; outputs must clear immediately.
    task automatic pulse_reset();
        @(negedge clock);
        load = 0;
        dec  = 1;
        #1 reset = 1;
        #1;
        check("async_rst_count", 32'(count), 0);
        check("async_rst_zero", 32'(zero), 1);
        check("async_rst_borrow", 32'(borrow_out), 0);
        check("async_rst_err", 32'(err), 0);
        @(negedge clock);
        reset = 0;
        dec   = 0;
        mval  = 0;
        merr  = 0;
    endtask

    // Monitor: every edge the DUT presents a new registered state.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("count", 32'(count), 32'(e.count));
            check("zero", 32'(zero), 32'(e.zero));
            check("borrow_out", 32'(borrow_out), 32'(e.borrow));
            check("err", 32'(err), 32'(e.err));
        end
    end

    initial begin
        reset = 1; load = 0; dec = 0; din = '0;
        mval = 0; merr = 0;
        #3;
        check("rst_count", 32'(count), 0);
        check("rst_zero", 32'(zero), 1);
        check("rst_borrow", 32'(borrow_out), 0);
        check("rst_err", 32'(err), 0);
        @(negedge clock);
        reset = 0;

        // load 16, one dec -> 15
        drive(1, 8'b00_01_10_01, 0);
        drive(0, '0, 1);
        // 9 -> 8, borrow spans two digits
        drive(1, 8'b00_01_00_00, 0);
        drive(0, '0, 1);
        // 16 decs to zero, then wrap with a one-cycle borrow
        drive(1, 8'b00_01_10_01, 0);
        for (int k = 0; k < 16; k++) drive(0, '0, 1);
        drive(0, '0, 1);
        drive(0, '0, 0);
        // illegal load holds count, legal load clears err
        drive(1, 8'b00_00_01_00, 0);
        drive(1, 8'b11_00_00_00, 0);
        drive(0, '0, 0);
        drive(1, 8'b00_00_00_10, 0);
        // load and dec together: no decrement
        drive(1, 8'b00_00_10_00, 1);
        // rejected load with dec: dec still ignored
        drive(1, 8'b00_11_00_00, 1);
        // wrap from zero via load
        drive(1, 8'b00_00_00_00, 0);
        drive(0, '0, 1);

        // randomized phase with a mid-run reset
        for (int c = 0; c < 400; c++) begin
            bit ld, dc;
            logic [2*N-1:0] d;
            if (c == 200) begin
                @(posedge clock);
                #2;
                pulse_reset();
            end
            ld = ($urandom_range(0, 9) == 0);
            dc = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) d = enc($urandom_range(0, 5));
            else if ($urandom_range(0, 1) == 1) d = enc($urandom_range(0, MAXV - 1));
            else d = 8'($urandom);
            drive(ld, d, dc);
        end

        @(negedge clock);
        load = 0;
        dec  = 0;
        for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(negedge clock);
        check("scoreboard_drained", 32'(sb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
